// File: rtl/fetch_unit_if.sv
// Fetch-unit boundary: branch redirect from execute, instruction-memory request/response
// port, and the decode-side valid/ready handshake.
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;

  logic                  imem_req_valid;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;

  logic                  dec_valid;
  logic [DATA_WIDTH-1:0] dec_instr;
  logic [DATA_WIDTH-1:0] dec_pc;
  logic [DATA_WIDTH-1:0] dec_pc_plus4;
  logic                  dec_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    input  dec_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    output dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order requests to instruction memory,
// a PC queue for in-flight fetches, and an instruction FIFO feeding decode.
module fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    FIFO_DEPTH   = 4
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t pc_plus4;
  } entry_t;

  word_t            fetch_pc;

  word_t            pcq_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] pcq_wr;
  logic [PTR_W-1:0] pcq_rd;
  logic [CNT_W-1:0] inflight_cnt;
  logic [CNT_W-1:0] drop_cnt;

  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] fifo_wr;
  logic [PTR_W-1:0] fifo_rd;
  logic [CNT_W-1:0] fifo_cnt;

  logic [CNT_W:0]   credit_used;
  logic             req_fire;
  logic             rsp_fire;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  word_t            rsp_pc;
  entry_t           head;

  // NOTE: combinational logic uses blocking assignments and gives every signal a value
  // on every path, so no latch can be inferred.
  always_comb begin
    credit_used = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
    fifo_empty  = (fifo_cnt == '0);
    rsp_pc      = pcq_mem[pcq_rd];
    head        = fifo_mem[fifo_rd];

    // A response is only meaningful when a request is outstanding; stray ones are ignored.
    rsp_fire = bus.imem_rsp_valid && (inflight_cnt != '0);
    push     = rsp_fire && (drop_cnt == '0) && !bus.redirect_valid;
    pop      = !fifo_empty && bus.dec_ready && !bus.redirect_valid;

    bus.imem_req_valid = rst_n && !bus.redirect_valid && (credit_used < CREDITS);
    bus.imem_req_addr  = fetch_pc;
    req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    bus.dec_valid    = !fifo_empty;
    bus.dec_instr    = fifo_empty ? '0 : head.instr;
    bus.dec_pc       = fifo_empty ? '0 : head.pc;
    bus.dec_pc_plus4 = fifo_empty ? '0 : head.pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_VECTOR;
      pcq_wr       <= '0;
      pcq_rd       <= '0;
      inflight_cnt <= '0;
      drop_cnt     <= '0;
      fifo_wr      <= '0;
      fifo_rd      <= '0;
      fifo_cnt     <= '0;
    end else begin
      if (bus.redirect_valid) begin
        fetch_pc <= {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + word_t'(4);
      end

      if (req_fire) pcq_wr <= pcq_wr + PTR_W'(1);
      if (rsp_fire) pcq_rd <= pcq_rd + PTR_W'(1);

      unique case ({req_fire, rsp_fire})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
        default: ;
      endcase

      // Everything still outstanding after this cycle's response belongs to the old path.
      if (bus.redirect_valid) begin
        drop_cnt <= inflight_cnt - CNT_W'(rsp_fire);
      end else if (rsp_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end

      if (bus.redirect_valid) begin
        fifo_rd  <= fifo_wr;
        fifo_cnt <= '0;
      end else begin
        if (push) fifo_wr <= fifo_wr + PTR_W'(1);
        if (pop)  fifo_rd <= fifo_rd + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
          2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // NOTE: the storage arrays are not reset; nothing reads an entry before it is written,
  // and the dec_* outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (req_fire) pcq_mem[pcq_wr] <= fetch_pc;
    if (push) begin
      fifo_mem[fifo_wr] <= '{instr: bus.imem_rsp_data, pc: rsp_pc, pc_plus4: rsp_pc + word_t'(4)};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with configurable latency and
// a scoreboard of accepted fetch PCs compared against what decode receives.
module tb_fetch_unit;

  localparam int          DW      = 32;
  localparam logic [31:0] RV      = 32'h0000_0100;
  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;
  localparam int          FREE    = 1000000;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fetch_unit_if #(.DATA_WIDTH(DW)) bus ();

  fetch_unit #(
    .DATA_WIDTH  (DW),
    .RESET_VECTOR(RV),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] sb[$];

  int          n_checks  = 0;
  int          n_pass    = 0;
  int          cycle     = 0;
  int          lat       = 1;
  int          budget    = 0;
  int          accepts   = 0;
  int          dec_fires = 0;
  int          first_acc = -1;
  int          first_dec = -1;
  logic [31:0] model_pc  = RV;
  logic        nxt_rst_n = 1'b0;
  logic        nxt_dec_ready = 1'b0;
  logic        want_first = 1'b0;
  logic [31:0] first_pc_exp = '0;
  logic        redir_rsp = 1'b0;
  logic        redir_pop = 1'b0;
  logic        wrap_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // One clock cycle: inputs change on the falling edge, outputs are sampled 1ns later,
  // and the model tracks whatever handshakes will complete on the next rising edge.
  task automatic step(input logic redir = 1'b0, input logic [31:0] rpc = '0);
    logic [31:0] exp_pc;
    pend_t       p;
    @(negedge clk);
    cycle++;
    rst_n              = nxt_rst_n;
    bus.dec_ready      = nxt_dec_ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    if (pend.size() > 0 && pend[0].due <= cycle) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = pend[0].addr ^ XOR_KEY;
      void'(pend.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    bus.imem_req_ready = (budget > 0);
    #1;
    if (!rst_n) begin
      check("rst_req_valid", 32'(bus.imem_req_valid), 0);
      check("rst_dec_valid", 32'(bus.dec_valid), 0);
      check("rst_dec_instr", bus.dec_instr, 0);
      check("rst_dec_pc", bus.dec_pc, 0);
      check("rst_dec_pc_plus4", bus.dec_pc_plus4, 0);
      sb.delete();
      model_pc = RV;
    end else if (redir) begin
      check("redir_no_req", 32'(bus.imem_req_valid), 0);
      redir_rsp = bus.imem_rsp_valid;
      redir_pop = bus.dec_valid && bus.dec_ready;
      sb.delete();
      model_pc = rpc & ~32'h3;
    end else begin
      if (bus.dec_valid && bus.dec_ready) begin
        dec_fires++;
        if (sb.size() == 0) begin
          check("dec_spurious", 32'(bus.dec_valid), 0);
        end else begin
          exp_pc = sb.pop_front();
          check("dec_pc", bus.dec_pc, exp_pc);
          check("dec_instr", bus.dec_instr, exp_pc ^ XOR_KEY);
          check("dec_pc_plus4", bus.dec_pc_plus4, exp_pc + 32'd4);
          if (exp_pc == 32'hFFFF_FFFC) begin
            check("wrap_pc_plus4", bus.dec_pc_plus4, 32'h0000_0000);
            wrap_seen = 1'b1;
          end
        end
        if (want_first) begin
          check("first_pc_after", bus.dec_pc, first_pc_exp);
          want_first = 1'b0;
        end
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("req_addr", bus.imem_req_addr, model_pc);
        p.addr = bus.imem_req_addr;
        p.due  = cycle + lat;
        pend.push_back(p);
        sb.push_back(model_pc);
        model_pc += 32'd4;
        budget--;
        accepts++;
        if (first_acc < 0) first_acc = cycle;
      end
      if (bus.dec_valid && first_dec < 0) first_dec = cycle;
    end
  endtask

  initial begin
    int fires0;
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.dec_ready      = 1'b0;

    // Reset, first fetch, two-cycle latency and one-per-cycle throughput.
    nxt_rst_n = 1'b0; nxt_dec_ready = 1'b1; lat = 1; budget = 0;
    repeat (2) step();
    nxt_rst_n = 1'b1; budget = FREE;
    step();
    check("first_req_valid", 32'(bus.imem_req_valid), 1);
    check("first_req_addr", bus.imem_req_addr, RV);
    for (int i = 0; i < 8 && first_dec < 0; i++) step();
    check("first_dec_latency", 32'(first_dec - first_acc), 2);
    fires0 = dec_fires;
    repeat (16) step();
    check("throughput", 32'(dec_fires - fires0), 16);

    // Decode stalled from reset: four credits, then issue stops with the head held.
    nxt_rst_n = 1'b0;
    repeat (2) step();
    nxt_rst_n = 1'b1; nxt_dec_ready = 1'b0; accepts = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.dec_valid) begin
        check("stall_hold_pc", bus.dec_pc, RV);
        check("stall_hold_instr", bus.dec_instr, RV ^ XOR_KEY);
      end
    end
    check("stall_accepts", 32'(accepts), 4);
    check("stall_req_valid", 32'(bus.imem_req_valid), 0);
    check("stall_dec_valid", 32'(bus.dec_valid), 1);
    nxt_dec_ready = 1'b1; accepts = 0;
    repeat (12) step();
    check("resume_issue", 32'(accepts >= 8), 1);

    // Redirect colliding with a response and a decode pop.
    step(1'b1, 32'h0000_3000);
    check("redir_had_rsp", 32'(redir_rsp), 1);
    check("redir_had_pop", 32'(redir_pop), 1);
    want_first = 1'b1; first_pc_exp = 32'h0000_3000;
    step();
    check("post_redir_dec_valid", 32'(bus.dec_valid), 0);
    check("post_redir_req_addr", bus.imem_req_addr, 32'h0000_3000);
    repeat (6) step();
    check("redir_target_seen", 32'(want_first), 0);

    // Three-cycle memory, redirect with two requests outstanding.
    budget = 0;
    repeat (8) step();
    lat = 3; budget = 2; accepts = 0;
    repeat (2) step();
    check("two_in_flight", 32'(accepts), 2);
    step(1'b1, 32'h0000_2003);
    want_first = 1'b1; first_pc_exp = 32'h0000_2000; budget = FREE;
    repeat (14) step();
    check("late_redir_target_seen", 32'(want_first), 0);

    // Fetch PC wrap-around.
    budget = 0;
    repeat (8) step();
    lat = 1; budget = FREE;
    step(1'b1, 32'hFFFF_FFFC);
    step();
    check("wrap_req_addr0", bus.imem_req_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_req_addr1", bus.imem_req_addr, 32'h0000_0000);
    repeat (6) step();
    check("wrap_seen", 32'(wrap_seen), 1);

    // Reset mid-stream with two responses still coming back afterwards.
    budget = 0;
    repeat (8) step();
    lat = 4; budget = 2;
    repeat (2) step();
    nxt_rst_n = 1'b0;
    step();
    nxt_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_idle", 32'(bus.dec_valid), 0);
    end
    lat = 1; budget = FREE;
    want_first = 1'b1; first_pc_exp = RV;
    repeat (8) step();
    check("post_rst_first_pc_seen", 32'(want_first), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within the time limit");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end for the pipelined core, replacing the single-cycle PC/instruction-memory block.
- Holds the fetch PC and issues in-order requests to a variable-latency instruction memory over a valid/ready port.
- Buffers returned instructions with their PC and PC+4 in an internal FIFO and presents them to decode over a valid/ready handshake.
- Supports branch/jump redirect, which flushes buffered instructions and discards responses still in flight.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instructions
RESET_VECTOR, 32'h0000_0000, fetch PC after reset
FIFO_DEPTH, 4, instruction buffer entries and maximum in-flight requests (power of 2, >= 2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
redirect_valid  input  1  redirect fetch this cycle (taken branch/jump from execute)
redirect_pc  input  DATA_WIDTH  new fetch PC; bits [1:0] ignored, treated as 0
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  DATA_WIDTH  fetch address (current fetch PC)
imem_req_ready  input  1  memory accepts request
imem_rsp_valid  input  1  response valid; responses return in request order
imem_rsp_data  input  DATA_WIDTH  instruction word
dec_valid  output  1  instruction available to decode
dec_instr  output  DATA_WIDTH  instruction
dec_pc  output  DATA_WIDTH  PC of dec_instr
dec_pc_plus4  output  DATA_WIDTH  dec_pc + 4, modulo 2^DATA_WIDTH
dec_ready  input  1  decode consumes the entry

Behaviour:
- Reset (async assert, sync deassert):
  - fetch_pc = RESET_VECTOR; FIFO empty; inflight_cnt = 0; drop_cnt = 0.
  - dec_valid, dec_instr, dec_pc and dec_pc_plus4 are all 0.
  - imem_req_valid = 0 while rst_n is low.
  - Reset mid-operation discards all state, including in-flight requests. A response arriving after reset with inflight_cnt = 0 is ignored.
- Issue:
  - imem_req_valid = !redirect_valid && (inflight_cnt + fifo_count < FIFO_DEPTH).
  - imem_req_addr = fetch_pc, held stable while valid && !ready.
  - Accept (valid && ready) increments fetch_pc by 4, with wrap-around modulo 2^DATA_WIDTH, and pushes fetch_pc onto an internal in-flight PC queue.
  - The credit rule guarantees the FIFO never overflows.
- Response:
  - When imem_rsp_valid && inflight_cnt > 0, pop the PC queue.
  - If drop_cnt > 0, discard the data and decrement drop_cnt.
  - Otherwise push {data, pc, pc+4} into the FIFO.
  - Response with inflight_cnt = 0: ignored, no state change.
- Latency:
  - Request accepted in cycle c with response in c+1 gives dec_valid in c+2. There is no combinational response-to-decode bypass.
  - With zero-wait memory and dec_ready = 1, sustained throughput is 1 instruction/cycle.
- Decode:
  - dec_valid = FIFO non-empty. The dec_* outputs show the FIFO head and are registered/stable while dec_valid && !dec_ready.
  - Pop on dec_valid && dec_ready.
  - Same-cycle push and pop on a full FIFO is legal: count is unchanged.
- Redirect (redirect_valid = 1):
  - fetch_pc <= {redirect_pc[DW-1:2], 2'b00}.
  - FIFO flushed; dec_valid = 0 next cycle.
  - drop_cnt <= inflight_cnt after accounting for any response in the same cycle. That response is itself dropped regardless of drop_cnt.
  - No request is issued in the redirect cycle. Fetch at the new PC starts the following cycle.
  - Redirect overrides a simultaneous dec pop and response push.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
  - Dropped responses free credits as they arrive.
- Counters:
  - inflight_cnt is 0..FIFO_DEPTH, incremented on accept and decremented on counted response; both in the same cycle leaves it unchanged.
  - drop_cnt <= inflight_cnt always holds.

Test Plan:
- Reset, RESET_VECTOR=0x100, zero-wait memory returning addr^0xA5A5_0000, dec_ready=1 -> first imem_req_addr 0x100 the cycle after rst_n rises; dec_valid 2 cycles after first accept. dec_pc then runs 0x100, 0x104, 0x108 with dec_pc_plus4 = dec_pc+4 and one instruction per cycle.
- dec_ready=0 from reset -> exactly 4 requests accepted, then imem_req_valid stays 0. dec_* remain stable on the 0x100 entry. On dec_ready=1 the entries drain in order and issue resumes as credits return.
- Memory with 3-cycle latency, redirect_valid with redirect_pc=0x2003 while 2 requests are in flight -> both late responses dropped. Next dec_pc is 0x2000, and no pre-redirect PC ever appears on decode after the redirect.
- Redirect in the same cycle as a response and a dec pop with dec_valid=1 -> response discarded, FIFO empty next cycle, dec_valid=0, fetch resumes at the redirect target.
- fetch_pc=0xFFFF_FFFC accepted -> dec_pc_plus4=0x0000_0000 and the next imem_req_addr is 0x0.
- rst_n pulsed low mid-stream with 2 requests in flight; memory still returns them after reset -> responses ignored, dec_valid stays 0 until new RESET_VECTOR fetches return, all outputs 0 during reset.
